// File: rtl/stack_op_sequencer.sv
// Sequences the multi-cycle CALL/RET/RTI/interrupt stack micro-ops injected into fetch.
// Outputs are decoded from registered state: a command accepted on edge N drives cycle N+1; enable_i=0 freezes everything.
module stack_op_sequencer #(
    parameter logic [4:0]  OP_PUSH_PC    = 5'b11111,
    parameter logic [4:0]  OP_PUSH_FLAGS = 5'b11110,
    parameter logic [4:0]  OP_JMP        = 5'b11011,
    parameter logic [4:0]  OP_POP_PC     = 5'b11100,
    parameter logic [4:0]  OP_POP_FLAGS  = 5'b11101,
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned POP_BUBBLES   = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        call_valid_i,
    input  logic        ret_valid_i,
    input  logic        rti_valid_i,
    input  logic [2:0]  rdst_call_i,
    input  logic        interupt_i,
    output logic        cmd_ready_o,
    output logic        inject_valid_o,
    output logic [15:0] inject_instr_o,
    output logic        fetch_hold_o,
    output logic [1:0]  pc_sel_o,
    output logic        int_ack_o
);

    typedef enum logic [3:0] {
        IDLE, CALL_PUSH, CALL_JMP, INT_DRAIN, INT_PUSH_PC, INT_PUSH_FL, INT_VEC,
        RTI_POP_FL, RTI_POP_PC, RET_POP_PC, POP_WAIT, POP_LOAD
    } state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
    localparam logic [2:0] POP_LOAD_N = 3'(POP_BUBBLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] rd_q, rd_d;
    logic       pend_q, pend_d;

    function automatic logic [15:0] uop(input logic [4:0] op, input logic [2:0] rd);
        return {op, 3'b000, rd, 5'b00000};
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        // The interrupt pin is captured even while frozen; entry into the drain consumes it.
        pend_d  = pend_q | interupt_i;
        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (call_valid_i) begin
                        state_d = CALL_PUSH;
                        rd_d    = rdst_call_i;
                    end else if (rti_valid_i) begin
                        state_d = RTI_POP_FL;
                    end else if (ret_valid_i) begin
                        state_d = RET_POP_PC;
                    end else if (pend_q || interupt_i) begin
                        state_d = INT_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                        pend_d  = 1'b0;
                    end
                end
                CALL_PUSH:   state_d = CALL_JMP;
                CALL_JMP:    state_d = IDLE;
                INT_DRAIN: begin
                    if (cnt_q == 3'd0) state_d = INT_PUSH_PC;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                INT_PUSH_PC: state_d = INT_PUSH_FL;
                INT_PUSH_FL: state_d = INT_VEC;
                INT_VEC:     state_d = IDLE;
                RTI_POP_FL:  state_d = RTI_POP_PC;
                RTI_POP_PC, RET_POP_PC: begin
                    state_d = POP_WAIT;
                    cnt_d   = POP_LOAD_N;
                end
                POP_WAIT: begin
                    if (cnt_q == 3'd0) state_d = POP_LOAD;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                POP_LOAD:    state_d = IDLE;
                default:     state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready_o    = 1'b0;
        inject_valid_o = 1'b1;
        inject_instr_o = 16'h0000;
        fetch_hold_o   = 1'b1;
        pc_sel_o       = 2'b00;
        int_ack_o      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o    = 1'b1;
                inject_valid_o = 1'b0;
                fetch_hold_o   = 1'b0;
            end
            CALL_PUSH:   inject_instr_o = uop(OP_PUSH_PC, 3'd0);
            CALL_JMP:    inject_instr_o = uop(OP_JMP, rd_q);
            INT_DRAIN:   int_ack_o      = (cnt_q == DRAIN_LOAD);
            INT_PUSH_PC: inject_instr_o = uop(OP_PUSH_PC, 3'd0);
            INT_PUSH_FL: inject_instr_o = uop(OP_PUSH_FLAGS, 3'd0);
            INT_VEC:     pc_sel_o       = 2'b01;
            RTI_POP_FL:  inject_instr_o = uop(OP_POP_FLAGS, 3'd0);
            RTI_POP_PC, RET_POP_PC: inject_instr_o = uop(OP_POP_PC, 3'd0);
            POP_LOAD:    pc_sel_o       = 2'b10;
            default: ;
        endcase
    end

endmodule
